// File: rtl/vec_mag_pkg.sv
// Shared definitions for the vector-magnitude pipeline and its feeders.
//   COORD_WIDTH_DFLT : default signed coordinate width in bits
//   seg_state_e      : segment-former state (EMPTY / HAVE_PREV)
//   seg_lsb()        : bit offset of a field inside a {x1, y1, x2, y2} segment word
//   SEG_*_LSB        : field offsets at the default width, for the magnitude core
package vec_mag_pkg;

  localparam int COORD_WIDTH_DFLT = 8;

  typedef enum logic {
    EMPTY     = 1'b0,
    HAVE_PREV = 1'b1
  } seg_state_e;

  // Field indices, MSB-first order inside the segment word.
  localparam int FLD_X1 = 0;
  localparam int FLD_Y1 = 1;
  localparam int FLD_X2 = 2;
  localparam int FLD_Y2 = 3;

  function automatic int seg_lsb(input int field, input int cw);
    return (3 - field) * cw;
  endfunction

  localparam int SEG_X1_LSB = seg_lsb(FLD_X1, COORD_WIDTH_DFLT);
  localparam int SEG_Y1_LSB = seg_lsb(FLD_Y1, COORD_WIDTH_DFLT);
  localparam int SEG_X2_LSB = seg_lsb(FLD_X2, COORD_WIDTH_DFLT);
  localparam int SEG_Y2_LSB = seg_lsb(FLD_Y2, COORD_WIDTH_DFLT);

endpackage

// File: rtl/vec_seg_former.sv
// Point-to-segment former feeding the vector-magnitude core.
// Turns an AXI-Stream of points {x, y} into segments {x1, y1, x2, y2}.
//   mode_i = 0 (polyline): consecutive points of a packet form segments.
//   mode_i = 1 (radius)  : each point forms a segment from the origin.
// Ports:
//   aclk, aresetn        clock, async active-low reset
//   s_axis_*             point input stream (tdata = {x, y})
//   m_axis_*             registered segment output stream (tdata = {x1,y1,x2,y2})
//   mode_i               segment mode, latched on the first point of a packet
//   clear_i              synchronous soft clear of state, output and counters
//   busy_o               a point is held or an output is pending
//   seg_cnt_o            segments handed downstream (wraps)
//   lone_pt_cnt_o        single-point polylines seen (wraps)
module vec_seg_former
  import vec_mag_pkg::*;
#(
  parameter int COORD_WIDTH = COORD_WIDTH_DFLT
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [2*COORD_WIDTH-1:0] s_axis_tdata,
  input  logic                     s_axis_tvalid,
  input  logic                     s_axis_tlast,
  output logic                     s_axis_tready,
  output logic [4*COORD_WIDTH-1:0] m_axis_tdata,
  output logic                     m_axis_tvalid,
  output logic                     m_axis_tlast,
  input  logic                     m_axis_tready,
  input  logic                     mode_i,
  input  logic                     clear_i,
  output logic                     busy_o,
  output logic [31:0]              seg_cnt_o,
  output logic [31:0]              lone_pt_cnt_o
);

  localparam int PW     = 2 * COORD_WIDTH;
  localparam int SW     = 4 * COORD_WIDTH;
  localparam int X1_LSB = seg_lsb(FLD_X1, COORD_WIDTH);
  localparam int Y1_LSB = seg_lsb(FLD_Y1, COORD_WIDTH);
  localparam int X2_LSB = seg_lsb(FLD_X2, COORD_WIDTH);
  localparam int Y2_LSB = seg_lsb(FLD_Y2, COORD_WIDTH);

  seg_state_e        state_q, state_d;
  logic [PW-1:0]     prev_q, prev_d;
  logic              mode_q, mode_d;
  logic [SW-1:0]     m_data_q, m_data_d;
  logic              m_valid_q, m_valid_d;
  logic              m_last_q, m_last_d;
  logic [31:0]       seg_cnt_q, seg_cnt_d;
  logic [31:0]       lone_cnt_q, lone_cnt_d;

  logic              emit_would_occur;
  logic              accept;
  logic              cur_mode;
  logic              emit;
  logic              m_hs;
  logic [SW-1:0]     seg_word;

  // Any accept in HAVE_PREV, or any accept in radius mode, produces a segment.
  // Uses the raw mode_i so a polyline start is never blocked by a stalled output.
  assign emit_would_occur = (state_q == HAVE_PREV) || mode_i;
  assign s_axis_tready    = !clear_i && (!emit_would_occur || !m_valid_q || m_axis_tready);
  assign accept           = s_axis_tvalid && s_axis_tready;
  // The latched mode governs the packet once its first point has been taken.
  assign cur_mode         = (state_q == EMPTY) ? mode_i : mode_q;
  assign emit             = accept && (cur_mode || (state_q == HAVE_PREV));
  assign m_hs             = m_valid_q && m_axis_tready;

  always_comb begin
    seg_word = '0;
    seg_word[X2_LSB +: COORD_WIDTH] = s_axis_tdata[PW-1 -: COORD_WIDTH];
    seg_word[Y2_LSB +: COORD_WIDTH] = s_axis_tdata[COORD_WIDTH-1:0];
    if (!cur_mode) begin
      seg_word[X1_LSB +: COORD_WIDTH] = prev_q[PW-1 -: COORD_WIDTH];
      seg_word[Y1_LSB +: COORD_WIDTH] = prev_q[COORD_WIDTH-1:0];
    end
  end

  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    mode_d     = mode_q;
    m_data_d   = m_data_q;
    m_valid_d  = m_valid_q;
    m_last_d   = m_last_q;
    seg_cnt_d  = seg_cnt_q;
    lone_cnt_d = lone_cnt_q;

    if (clear_i) begin
      state_d    = EMPTY;
      m_valid_d  = 1'b0;
      m_last_d   = 1'b0;
      seg_cnt_d  = '0;
      lone_cnt_d = '0;
    end else begin
      if (m_hs) begin
        seg_cnt_d = seg_cnt_q + 32'd1;
        m_valid_d = 1'b0;
      end
      // A new segment overrides the drain so back-to-back segments keep tvalid high.
      if (emit) begin
        m_data_d  = seg_word;
        m_valid_d = 1'b1;
        m_last_d  = s_axis_tlast;
      end
      if (accept) begin
        if (state_q == EMPTY) mode_d = mode_i;
        if (!cur_mode) prev_d = s_axis_tdata;
        if (!cur_mode && (state_q == EMPTY) && s_axis_tlast) begin
          lone_cnt_d = lone_cnt_q + 32'd1;
          state_d    = EMPTY;
        end else begin
          state_d = s_axis_tlast ? EMPTY : HAVE_PREV;
        end
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= EMPTY;
      prev_q     <= '0;
      mode_q     <= 1'b0;
      m_data_q   <= '0;
      m_valid_q  <= 1'b0;
      m_last_q   <= 1'b0;
      seg_cnt_q  <= '0;
      lone_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      mode_q     <= mode_d;
      m_data_q   <= m_data_d;
      m_valid_q  <= m_valid_d;
      m_last_q   <= m_last_d;
      seg_cnt_q  <= seg_cnt_d;
      lone_cnt_q <= lone_cnt_d;
    end
  end

  assign m_axis_tdata  = m_data_q;
  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tlast  = m_last_q;
  assign busy_o        = (state_q == HAVE_PREV) || m_valid_q;
  assign seg_cnt_o     = seg_cnt_q;
  assign lone_pt_cnt_o = lone_cnt_q;

endmodule

// File: doc/vec_seg_former.md
Name: vec_seg_former

Overview:
- Upstream feeder for the vector-magnitude pipeline core.
- Converts an AXI-Stream of points {x, y} into an AXI-Stream of segments {x1, y1, x2, y2}, which is the core's input format.
- Polyline mode: consecutive points within a packet (delimited by tlast) form segments.
- Radius mode: each point forms a segment from the origin.
- Full backpressure; status counters go to the control/status register block.

Parameters:
- COORD_WIDTH, 8, signed coordinate width in bits; segment word is 4*COORD_WIDTH.

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- s_axis_tdata  in  2*COORD_WIDTH  point, {x, y}; x in the upper half; two's complement
- s_axis_tvalid  in  1  point valid
- s_axis_tlast  in  1  last point of polyline
- s_axis_tready  out  1  point accepted when tvalid && tready
- m_axis_tdata  out  4*COORD_WIDTH  segment {x1, y1, x2, y2}, x1 in the MSBs
- m_axis_tvalid  out  1  segment valid
- m_axis_tlast  out  1  segment ends the polyline
- m_axis_tready  in  1  downstream ready
- mode_i  in  1  0 = polyline, 1 = radius (origin to point)
- clear_i  in  1  synchronous soft clear
- busy_o  out  1  a point is held or an output is pending
- seg_cnt_o  out  32  segments accepted downstream
- lone_pt_cnt_o  out  32  polylines with a single point (no segment produced)

Behaviour:
- Reset: one clock (aclk). Asynchronous, active-low (aresetn); no other reset polarity or synchronicity is permitted.
- Reset values: state = EMPTY, prev point = 0, m_axis_tvalid = 0, m_axis_tdata = 0, m_axis_tlast = 0, both counters = 0, mode latch = 0.
- Reset mid-operation discards the held point and any pending output with no partial emission.
- State machine:
  - EMPTY: no previous point held.
  - HAVE_PREV: previous point held in register prev.
- Mode latch: mode_i is sampled on every accept in EMPTY; the latched value governs the polyline until its tlast. Changes to mode_i mid-polyline are ignored.
- Output register: m_axis_tdata, m_axis_tvalid and m_axis_tlast are registered, with standard AXIS rules:
  - Data is stable while tvalid && !tready.
  - tvalid never drops without a handshake.
- emit = accepted point produces a segment.
- s_axis_tready = !emit_would_occur || !m_axis_tvalid || m_axis_tready.
  - emit_would_occur = (state == HAVE_PREV) || mode_i, evaluated combinationally.
  - In EMPTY in polyline mode, a point is always accepted, even while the output is stalled.
- Polyline mode (latched 0):
  - EMPTY, accept, tlast = 0: prev <= point; go to HAVE_PREV; no emit.
  - EMPTY, accept, tlast = 1: lone point. lone_pt_cnt++, stay in EMPTY, no emit.
  - HAVE_PREV, accept: emit {prev, point} with m_axis_tlast = s_axis_tlast; prev <= point. Next state is EMPTY if tlast, else HAVE_PREV.
- Radius mode (latched 1):
  - Every accept emits {0, 0, x, y} with m_axis_tlast = s_axis_tlast.
  - State goes to HAVE_PREV if !tlast, else EMPTY. prev is unused.
- Latency: segment valid on the cycle after the accept of its second point (1 cycle).
- Throughput: 1 segment per clock with m_axis_tready held high.
- Load and drain in the same cycle: if a new emit and an output handshake coincide, the output register loads the new segment and tvalid stays 1.
- seg_cnt_o increments on each m_axis handshake. lone_pt_cnt_o increments on each lone point. Both wrap modulo 2^32.
- clear_i (sync, highest priority after reset):
  - Effects next edge: state = EMPTY, m_axis_tvalid = 0, counters = 0.
  - An input accepted in the same cycle is dropped.
  - clear_i forces s_axis_tready = 0 while high.
- busy_o = (state == HAVE_PREV) || m_axis_tvalid.
- Width rules: coordinates pass through unmodified; no arithmetic on data, so no overflow is possible in this block.

Decomposition:
- Shared package vec_mag_pkg:
  - COORD_WIDTH default.
  - Enum seg_state_e {EMPTY, HAVE_PREV}.
  - Field-slicing constants (X1/Y1/X2/Y2 bit offsets), shared with the magnitude core.
- No sub-module required. The output register is an inline single-entry stage; a separate skid buffer is not used.

Test Plan:
- Polyline: mode 0, points (1,2), (4,6), (-3,0, tlast), m_tready = 1 -> two segments, 0x01020406 (tlast 0) then 0x0406FD00 (tlast 1). seg_cnt = 2.
- Lone point and back-to-back packets: (5,5, tlast) then (1,1), (2,2, tlast) -> no output for the first packet. lone_pt_cnt = 1; single segment 0x01010202 with tlast 1.
- Backpressure: stream of 4 points with m_tready low for 3 cycles after the first segment -> m_tdata/tvalid/tlast held stable. s_tready = 0 while emit is pending. Segments arrive in order with none lost or duplicated.
- Radius mode: mode 1, points (3,-4), (7,8, tlast) -> 0x000003FC (tlast 0), 0x00000708 (tlast 1). Toggling mode_i mid-packet has no effect.
- Reset/clear: assert aresetn = 0 asynchronously between the 2nd and 3rd points -> outputs 0 immediately. The next packet starts fresh, with its first point not paired with a stale prev. Repeat with clear_i -> same, and counters return to 0.
